hex7seg_scan_driver: RTL and testbench
======================================

# hex7seg_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits, generalising the single-digit hex glyph decoder to DIGITS digits sharing one segment bus. It latches a packed hex value once per scan frame, cycles a one-hot digit select at a programmable rate, and adds per-digit blanking, blinking, decimal points, leading-zero suppression and anti-ghosting dead time. It sits between the project datapath and the board display pins.

## Interface
- DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 50000, clock cycles per digit slot (≥2)
- BLINK_DIV, 25, scan frames per blink half-period (≥1)
- SEG_ACTIVE_LOW, 1, 1: segment/dp outputs active-low; 0: active-high
- AN_ACTIVE_LOW, 1, 1: anode outputs active-low; 0: active-high
- clk  input  1  system clock; single clock domain
- rst_n  input  1  asynchronous active-low reset
- en  input  1  1: scanning; 0: display dark, counters hold
- value  input  4*DIGITS  packed nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost
- dp_in  input  DIGITS  decimal point request per digit
- blank_mask  input  DIGITS  1 forces digit dark
- blink_mask  input  DIGITS  1 makes digit dark during blink-off phase
- lzb  input  1  leading-zero blanking enable
- seg  output  7  segments {g,f,e,d,c,b,a}, bit 0 = a
- dp  output  1  decimal point segment
- an  output  DIGITS  one-hot digit enable
- frame_tick  output  1  one-cycle pulse when the digit index wraps DIGITS-1 → 0

## Operation
- Glyphs (logical, 1 = lit, before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. Active-low output is bitwise inverse (e.g. 0 → 7'b1000000).
- Prescaler pcnt counts 0..SCAN_DIV-1 while en=1; at terminal count it wraps to 0 and digit index idx advances, idx wraps DIGITS-1 → 0.
- On idx wrap: value, dp_in, blank_mask, blink_mask, lzb copied into shadow registers; frame_tick pulses; frame counter fcnt advances 0..BLINK_DIV-1, and at its terminal count wraps and toggles blink_phase (0 = on, 1 = off).
- All glyph/blank decisions use shadow registers only; input changes mid-frame never alter the current frame.
- Digit idx is dark when any holds: shadow blank_mask[idx]; shadow blink_mask[idx] and blink_phase=1; shadow lzb=1, idx≠0, and all shadow nibbles idx..DIGITS-1 are zero (digit 0 never suppressed by lzb).
- Dark digit: an all inactive, seg and dp inactive for the whole slot.
- Lit digit: an[idx] active, seg = glyph(nibble idx), dp active iff shadow dp_in[idx].
- Dead time: during pcnt==0 of every slot, an is all inactive (seg already shows the new digit) to prevent ghosting.
- en=0: pcnt, idx, fcnt, blink_phase hold; an, seg, dp inactive; frame_tick 0. Re-asserting en resumes from held state.

## Timing
- Reset (async assert, release synchronous to clk): pcnt=0, idx=0, fcnt=0, blink_phase=0, shadows=0 (blank_mask shadow=all 1s so nothing lights before first frame load), an/seg/dp inactive, frame_tick=0.
- First shadow load happens at the first idx wrap after reset; until then display is dark.
- Outputs are registered: an/seg/dp reflect idx and pcnt values with 1-cycle latency; frame_tick is registered, asserted in the cycle after the wrap edge, for exactly 1 cycle.
- Slot length exactly SCAN_DIV cycles; frame length DIGITS*SCAN_DIV; blink half-period BLINK_DIV frames.
- Active anode time per slot = SCAN_DIV-1 cycles.
- Reset mid-frame: outputs go inactive immediately (asynchronous), all state as above.

## Test plan
- DIGITS=4, SCAN_DIV=4, value=16'h1234, masks 0, lzb=0 → after first frame, an cycles digit0..3 each 3 cycles lit + 1 dead, seg (active-low) 0011001,0110000,0100100,1111001; frame_tick every 16 cycles.
- value=16'h0050, lzb=1 → digits 3,2 dark; digit1 shows 5 (0010010), digit0 shows 0 (1000000); value=16'h0000 → only digit0 lit with 0.
- Change value mid-frame from 16'h1111 to 16'h2222 → current frame completes with 1s; 2s appear only after next frame_tick.
- blink_mask=4'b0010, BLINK_DIV=2 → digit1 lit 2 frames, dark 2 frames, repeating; others always lit. dp_in=4'b0100 → dp active only in digit2 slots.
- Deassert en for 10 cycles mid-slot → an/seg/dp inactive, no frame_tick; on re-enable scan resumes at same idx/pcnt.
- Assert rst_n=0 mid-slot asynchronously (between clk edges) → an, seg, dp inactive immediately; after release display dark until first frame_tick, then normal.

Source files
------------

// File: rtl/hex7seg_if.sv
// Display-side bundle of the multiplexed seven-segment driver: datapath
// requests in, registered segment/anode pins and frame pulse out.
interface hex7seg_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_mask;
  logic [DIGITS-1:0]     blink_mask;
  logic                  lzb;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (
    output en, value, dp_in, blank_mask, blink_mask, lzb,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  en, value, dp_in, blank_mask, blink_mask, lzb,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/hex7seg_scan_driver.sv
// Time-multiplexed hex driver for DIGITS common-anode digits on one segment bus,
// with per-frame input snapshot, blanking, blinking, leading-zero suppression and dead time.
module hex7seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 25,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  hex7seg_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]       pcnt_reg;
  logic [IW-1:0]       idx_reg;
  logic [FW-1:0]       fcnt_reg;
  logic                blink_phase_reg;

  logic [4*DIGITS-1:0] sh_value_reg;
  logic [DIGITS-1:0]   sh_dp_reg;
  logic [DIGITS-1:0]   sh_blank_reg;
  logic [DIGITS-1:0]   sh_blink_reg;
  logic                sh_lzb_reg;

  logic [DIGITS-1:0]   an_reg;
  logic [6:0]          seg_reg;
  logic                dp_reg;
  logic                frame_tick_reg;

  logic                pcnt_last;
  logic                idx_last;
  logic                fcnt_last;
  logic                wrap;

  assign pcnt_last = (pcnt_reg == PW'(SCAN_DIV - 1));
  assign idx_last  = (idx_reg == IW'(DIGITS - 1));
  assign fcnt_last = (fcnt_reg == FW'(BLINK_DIV - 1));
  assign wrap      = bus.en && pcnt_last && idx_last;

  // Scan counters; everything freezes while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_reg        <= '0;
      idx_reg         <= '0;
      fcnt_reg        <= '0;
      blink_phase_reg <= 1'b0;
    end else if (bus.en) begin
      pcnt_reg <= pcnt_last ? '0 : pcnt_reg + 1'b1;
      if (pcnt_last) begin
        idx_reg <= idx_last ? '0 : idx_reg + 1'b1;
      end
      if (wrap) begin
        fcnt_reg <= fcnt_last ? '0 : fcnt_reg + 1'b1;
        if (fcnt_last) begin
          blink_phase_reg <= ~blink_phase_reg;
        end
      end
    end
  end

  // Blank shadow resets to all ones so nothing lights before the first snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value_reg <= '0;
      sh_dp_reg    <= '0;
      sh_blank_reg <= '1;
      sh_blink_reg <= '0;
      sh_lzb_reg   <= 1'b0;
    end else if (wrap) begin
      sh_value_reg <= bus.value;
      sh_dp_reg    <= bus.dp_in;
      sh_blank_reg <= bus.blank_mask;
      sh_blink_reg <= bus.blink_mask;
      sh_lzb_reg   <= bus.lzb;
    end
  end

  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] zero_from;
  logic              zero_run;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nib[gi] = sh_value_reg[4*gi +: 4];
    end
  endgenerate

  // zero_from[i]: every shadow nibble from i up to the leftmost digit is zero.
  always_comb begin
    zero_run  = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (nib[i] == 4'h0);
      zero_from[i] = zero_run;
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  logic              dark;
  logic              lit;
  logic [DIGITS-1:0] an_next;
  logic [6:0]        seg_next;
  logic              dp_next;

  // Segments switch at the slot start while anodes stay off for pcnt==0 (anti-ghosting).
  always_comb begin
    dark = sh_blank_reg[idx_reg]
        || (sh_blink_reg[idx_reg] && blink_phase_reg)
        || (sh_lzb_reg && (idx_reg != '0) && zero_from[idx_reg]);
    lit      = bus.en && !dark;
    an_next  = '0;
    seg_next = '0;
    dp_next  = 1'b0;
    if (lit) begin
      seg_next = glyph(nib[idx_reg]);
      dp_next  = sh_dp_reg[idx_reg];
      if (pcnt_reg != '0) begin
        an_next = {{(DIGITS-1){1'b0}}, 1'b1} << idx_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg         <= '0;
      seg_reg        <= '0;
      dp_reg         <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      dp_reg         <= dp_next;
      frame_tick_reg <= wrap;
    end
  end

  // Registers hold logical (1 = lit) values; pin polarity is applied here.
  assign bus.an         = AN_ACTIVE_LOW  ? ~an_reg  : an_reg;
  assign bus.seg        = SEG_ACTIVE_LOW ? ~seg_reg : seg_reg;
  assign bus.dp         = SEG_ACTIVE_LOW ? ~dp_reg  : dp_reg;
  assign bus.frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_hex7seg_scan_driver.sv
// Directed bench for hex7seg_scan_driver: DIGITS=4, SCAN_DIV=4, BLINK_DIV=2,
// active-low segments and anodes; expectations are hand-computed pin patterns.
module tb_hex7seg_scan_driver;
  localparam int DIGITS = 4;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] OFF = 7'b1111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  hex7seg_if #(.DIGITS(DIGITS)) bus ();

  hex7seg_scan_driver #(
    .DIGITS(DIGITS),
    .SCAN_DIV(4),
    .BLINK_DIV(2),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, 16'(bus.an), 16'h000F);
    chk({tag, "_seg"}, 16'(bus.seg), 16'(OFF));
    chk({tag, "_dp"}, 16'(bus.dp), 16'h0001);
    chk({tag, "_tick"}, 16'(bus.frame_tick), 16'h0000);
    $display("%s: display dark check done", tag);
  endtask

  // Bounded search for the next frame_tick; leaves the bench at frame sample k=0.
  task automatic wait_tick(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (bus.frame_tick === 1'b1) got = 1'b1;
    end
    chk({tag, "_wait"}, 16'(got), 16'h0001);
  endtask

  // Sample k (k-th edge after the wrap) shows digit (k-1)/4 at slot cycle (k-1)%4.
  task automatic check_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] lit, input logic [3:0] dpm,
                             input int klo, input int khi);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = klo; k <= khi; k++) begin
      int d;
      int p;
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      step();
      d  = (k - 1) / 4;
      p  = (k - 1) % 4;
      ea = (lit[d] && p != 0) ? ~(4'b0001 << d) : 4'hF;
      es = lit[d] ? s[d] : OFF;
      ed = (lit[d] && dpm[d]) ? 1'b0 : 1'b1;
      chk($sformatf("%s_an_k%0d", tag, k), 16'(bus.an), 16'(ea));
      chk($sformatf("%s_seg_k%0d", tag, k), 16'(bus.seg), 16'(es));
      chk($sformatf("%s_dp_k%0d", tag, k), 16'(bus.dp), 16'(ed));
      chk($sformatf("%s_tick_k%0d", tag, k), 16'(bus.frame_tick), 16'(k == 16));
    end
    $display("%s: frame samples %0d..%0d checked", tag, klo, khi);
  endtask

  initial begin
    bus.en         = 1'b1;
    bus.value      = 16'h1234;
    bus.dp_in      = 4'b0000;
    bus.blank_mask = 4'b0000;
    bus.blink_mask = 4'b0000;
    bus.lzb        = 1'b0;

    repeat (2) step();
    chk_dark("reset");
    rst_n = 1'b1;
    repeat (5) step();
    chk_dark("prefirst");
    wait_tick("tick1");

    check_frame("f1_1234", S4, S3, S2, S1, 4'b1111, 4'b0000, 1, 16);
    check_frame("f2_1234", S4, S3, S2, S1, 4'b1111, 4'b0000, 1, 16);

    bus.value = 16'h0050;
    bus.lzb   = 1'b1;
    check_frame("f3_shadow", S4, S3, S2, S1, 4'b1111, 4'b0000, 1, 16);
    check_frame("f4_lzb0050", S0, S5, OFF, OFF, 4'b0011, 4'b0000, 1, 16);

    bus.value = 16'h0000;
    check_frame("f5_lzb0050", S0, S5, OFF, OFF, 4'b0011, 4'b0000, 1, 16);
    check_frame("f6_lzb0000", S0, OFF, OFF, OFF, 4'b0001, 4'b0000, 1, 16);

    bus.value = 16'h1111;
    bus.lzb   = 1'b0;
    check_frame("f7_lzb0000", S0, OFF, OFF, OFF, 4'b0001, 4'b0000, 1, 16);
    bus.value = 16'h2222;
    check_frame("f8_1111", S1, S1, S1, S1, 4'b1111, 4'b0000, 1, 16);
    check_frame("f9_2222", S2, S2, S2, S2, 4'b1111, 4'b0000, 1, 16);

    // Frames after wrap n are in blink-off phase when n mod 4 is 2 or 3.
    bus.blink_mask = 4'b0010;
    bus.dp_in      = 4'b0100;
    check_frame("f10_plain", S2, S2, S2, S2, 4'b1111, 4'b0000, 1, 16);
    check_frame("f11_blkoff", S2, S2, S2, S2, 4'b1101, 4'b0100, 1, 16);
    check_frame("f12_blkon", S2, S2, S2, S2, 4'b1111, 4'b0100, 1, 16);
    check_frame("f13_blkon", S2, S2, S2, S2, 4'b1111, 4'b0100, 1, 16);
    check_frame("f14_blkoff", S2, S2, S2, S2, 4'b1101, 4'b0100, 1, 16);

    bus.blink_mask = 4'b0000;
    bus.blank_mask = 4'b1000;
    bus.dp_in      = 4'b0000;
    check_frame("f15_blkoff", S2, S2, S2, S2, 4'b1101, 4'b0100, 1, 16);
    check_frame("f16_blank3", S2, S2, S2, OFF, 4'b0111, 4'b0000, 1, 16);

    check_frame("f17_pre_en", S2, S2, S2, OFF, 4'b0111, 4'b0000, 1, 5);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_dark($sformatf("en_off_%0d", i));
    end
    bus.en = 1'b1;
    check_frame("f17_resume", S2, S2, S2, OFF, 4'b0111, 4'b0000, 6, 16);

    repeat (3) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk_dark("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) step();
    chk_dark("post_rst");
    wait_tick("tick_after_rst");
    check_frame("f_after_rst", S2, S2, S2, OFF, 4'b0111, 4'b0000, 1, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
